// File: rtl/addsub_seq_if.sv
// Operand/result bundle for the chunked adder/subtractor.
// The master side issues start, mode, a, b and cin; the slave side returns
// the status strobes, the result and the flags.
interface addsub_seq_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: operands are captured on start and summed
// CHUNK bits per clock, least-significant chunk first, through one
// CHUNK-bit carry chain. Results and flags update only on completion.
module addsub_seq #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 2
) (
    input  logic        clk,
    input  logic        rst,
    addsub_seq_if.slave bus
);
    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
    localparam int CNT_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_param_check
        $error("addsub_seq: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_next_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic             capture_s;
    logic             last_s;
    logic             carry_init_s;
    logic             msb_cin_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             neg_r;

    // Initial carry of the chain: 0 for ADD, 1 for SUB, cin for ADC/SBC.
    always_comb begin
        carry_init_s = 1'b0;
        case (bus.mode)
            2'b00:   carry_init_s = 1'b0;
            2'b01:   carry_init_s = bus.cin;
            2'b10:   carry_init_s = 1'b1;
            2'b11:   carry_init_s = bus.cin;
            default: carry_init_s = 1'b0;
        endcase
    end

    // One chunk of the add; operand registers shift down so the low chunk is always current.
    always_comb begin
        chunk_sum_s = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_r};
        // Carry into the MSB recovered from its sum bit; only meaningful on the final chunk.
        msb_cin_s   = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
        // New chunk enters at the top; after NCHUNK steps the first chunk reaches bit 0.
        res_next_s  = (res_r >> CHUNK) | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // Capture and last-chunk qualifiers; start is only honoured in IDLE or DONE.
    always_comb begin
        capture_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_s    = (state_r == ST_BUSY) && (cnt_r == LAST_CNT);
    end

    // Next-state logic of the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_next_s = ST_BUSY;
                else           state_next_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_s) state_next_s = ST_DONE;
                else        state_next_s = ST_BUSY;
            end
            ST_DONE: begin
                if (bus.start) state_next_s = ST_BUSY;
                else           state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_BUSY);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, chunk iteration and final result/flag write.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
        end else if (capture_s) begin
            a_r     <= bus.a;
            b_r     <= bus.mode[1] ? ~bus.b : bus.b;
            res_r   <= {WIDTH{1'b0}};
            carry_r <= carry_init_s;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (state_r == ST_BUSY) begin
            a_r     <= a_r >> CHUNK;
            b_r     <= b_r >> CHUNK;
            res_r   <= res_next_s;
            carry_r <= chunk_sum_s[CHUNK];
            cnt_r   <= cnt_r + CNT_W'(1);
            if (last_s) begin
                sum_r  <= res_next_s;
                cout_r <= chunk_sum_s[CHUNK];
                ovf_r  <= msb_cin_s ^ chunk_sum_s[CHUNK];
                zero_r <= (res_next_s == {WIDTH{1'b0}});
                neg_r  <= res_next_s[WIDTH-1];
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;
    assign bus.neg  = neg_r;
endmodule
